// File: rtl/riscv_pkg.sv
// Shared types for the RV32I fetch/sequencing controller.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_BREAK = 3'd4
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/riscv_fetch_ctrl_bp_match.sv
// PC breakpoint comparators: one-hot match (lowest index wins) plus any-match.
module bp_match #(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 2
) (
    input  logic [XLEN-1:0]        pc,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*XLEN-1:0] bp_addr,
    output logic [NUM_BP-1:0]      match,
    output logic                   any_match
);

    logic found;

    always_comb begin
        match = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (!found && bp_en[i] && (bp_addr[i*XLEN +: XLEN] == pc)) begin
                match[i] = 1'b1;
                found    = 1'b1;
            end
        end
        any_match = found;
    end

endmodule

// File: rtl/riscv_fetch_ctrl.sv
// Fetch controller: owns the PC, run/step/break sequencing and the program-load port.
//
// state  | meaning
// IDLE   | halted; accepts load, step, start and manual jog
// LOAD   | writing program words into instruction memory
// RUN    | free-running fetch, breakpoints armed
// STEP   | executes exactly one instruction, then back to IDLE
// BREAK  | halted on a breakpoint, pc parked on the matched instruction
module riscv_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int             XLEN       = 32,
    parameter int             IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int             NUM_BP     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          step,
    input  logic                          Up,
    input  logic                          Down,
    input  logic                          redirect_en,
    input  logic [XLEN-1:0]               redirect_target,
    input  logic [NUM_BP-1:0]             bp_en,
    input  logic [NUM_BP*XLEN-1:0]        bp_addr,
    input  logic                          ld_en,
    input  logic [31:0]                   ld_instr,
    output logic [XLEN-1:0]               pc,
    output logic [XLEN-1:0]               pc_plus_4,
    output logic                          instr_valid,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    output logic [31:0]                   imem_wdata,
    output logic [NUM_BP-1:0]             bp_hit,
    output logic                          ld_overflow,
    output logic                          misalign,
    output logic [2:0]                    state
);

    localparam int              AW     = $clog2(IMEM_DEPTH);
    localparam logic [XLEN-1:0] STRIDE = XLEN'(INSTR_BYTES);
    localparam logic [AW-1:0]   PTR_MAX = AW'(IMEM_DEPTH - 1);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [AW-1:0]   ld_ptr;
    logic            step_q;
    logic            resume_skip;

    logic              step_rise;
    logic              bp_stop;
    logic              take_redirect;
    logic [XLEN-1:0]   exec_pc;
    logic [NUM_BP-1:0] bp_vec;
    logic              bp_any;

    bp_match #(
        .XLEN   (XLEN),
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .pc        (pc_q),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .match     (bp_vec),
        .any_match (bp_any)
    );

    assign step_rise = step & ~step_q;
    assign pc_plus_4 = pc_q + STRIDE;

    // The first RUN cycle after leaving IDLE ignores breakpoints so a halted PC can resume.
    assign bp_stop = bp_any && !resume_skip;

    assign instr_valid = (state_q == ST_STEP) ||
                         ((state_q == ST_RUN) && start && !bp_stop);

    assign imem_we    = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && ld_en;
    assign imem_wdata = imem_we ? ld_instr : 32'h0;
    assign imem_waddr = ld_ptr;

    assign take_redirect = instr_valid && redirect_en;
    assign exec_pc       = take_redirect ? {redirect_target[XLEN-1:2], 2'b00} : pc_plus_4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_VEC;
            ld_ptr      <= '0;
            step_q      <= 1'b0;
            resume_skip <= 1'b0;
            bp_hit      <= '0;
            ld_overflow <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            step_q      <= step;
            resume_skip <= 1'b0;

            if (imem_we) begin
                ld_ptr <= (ld_ptr == PTR_MAX) ? '0 : ld_ptr + AW'(1);
                if (ld_ptr == PTR_MAX) ld_overflow <= 1'b1;
            end

            if (instr_valid) pc_q <= exec_pc;
            if (take_redirect && (redirect_target[1:0] != 2'b00)) misalign <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (ld_en) begin
                        state_q <= ST_LOAD;
                    end else if (step_rise) begin
                        state_q <= ST_STEP;
                    end else if (start) begin
                        state_q     <= ST_RUN;
                        resume_skip <= 1'b1;
                    end else if (Up && !Down) begin
                        pc_q <= pc_q + STRIDE;
                    end else if (Down && !Up) begin
                        pc_q <= pc_q - STRIDE;
                    end
                end
                ST_LOAD: begin
                    if (!ld_en) state_q <= ST_IDLE;
                end
                ST_RUN: begin
                    if (!start) begin
                        state_q <= ST_IDLE;
                    end else if (bp_stop) begin
                        state_q <= ST_BREAK;
                        bp_hit  <= bp_hit | bp_vec;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_IDLE;
                end
                ST_BREAK: begin
                    if (step_rise) state_q <= ST_STEP;
                    else if (!start) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pc    = pc_q;
    assign state = state_q;

endmodule
